aes_req_scheduler: RTL and testbench

- Shares one AES-128 encrypt/decrypt core between two requesters (ch0, ch1).
- Each requester hands over a block, a key and an encrypt/decrypt mode with a valid/ready handshake.
- The scheduler arbitrates round-robin, issues a one-cycle start to the core and requests a key-schedule reload only when the key differs from the one last loaded.
- It waits for core completion or a timeout, then returns a tagged result through a valid/ready response port.

---
 rtl/aes_sched_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/aes_req_scheduler.sv | 148 ++++++++++++++
 tb/tb_aes_req_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-channel AES request scheduler.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the channel that did not win last time is granted.
module rr_arbiter2
    import aes_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = CH0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[1]) begin
            gnt_id = CH1;
        end

        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = (gnt_id == CH1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES-128 core between two requesters; round-robin issue, key reload only on key change,
// timeout-protected wait and a tagged valid/ready response.
//
// state | meaning
// IDLE  | waiting for a request; rX_ready offered to the granted channel
// ISSUE | one-cycle core_start, loaded key bookkeeping
// WAIT  | waiting for core_done or timeout
// RESP  | response held until rsp_ready
module aes_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_encrypt,
    input  logic [DATA_W-1:0] r0_data,
    input  logic [DATA_W-1:0] r0_key,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_encrypt,
    input  logic [DATA_W-1:0] r1_data,
    input  logic [DATA_W-1:0] r1_key,

    input  logic              key_flush,

    output logic              core_start,
    output logic              core_sel_cypher,
    output logic              core_key_change,
    output logic [DATA_W-1:0] core_data_in,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_data_out,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // WAIT ends on the cycle the incremented count would reach TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    sched_state_t      state;
    logic              last_grant;
    logic              key_loaded;
    logic [DATA_W-1:0] loaded_key;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        gnt;
    logic              gnt_id;
    logic              hs;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_key;
    logic              sel_enc;

    rr_arbiter2 u_arb (
        .req        ({r1_valid, r0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign r0_ready = (state == IDLE) && gnt[0];
    assign r1_ready = (state == IDLE) && gnt[1];
    assign hs       = (state == IDLE) && (gnt != 2'b00);
    assign sel_data = (gnt_id == CH1) ? r1_data    : r0_data;
    assign sel_key  = (gnt_id == CH1) ? r1_key     : r0_key;
    assign sel_enc  = (gnt_id == CH1) ? r1_encrypt : r0_encrypt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            last_grant      <= CH1;
            key_loaded      <= 1'b0;
            loaded_key      <= '0;
            cnt             <= '0;
            core_start      <= 1'b0;
            core_sel_cypher <= 1'b0;
            core_key_change <= 1'b0;
            core_data_in    <= '0;
            core_key        <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= CH0;
            rsp_err         <= 1'b0;
            rsp_data        <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        core_data_in    <= sel_data;
                        core_key        <= sel_key;
                        core_sel_cypher <= sel_enc;
                        rsp_id          <= gnt_id;
                        core_start      <= 1'b1;
                        // key_change is registered here, so it must see the flag as it will be during ISSUE
                        core_key_change <= !(key_loaded && !key_flush) || (sel_key != loaded_key);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_key_change <= 1'b0;
                    loaded_key      <= core_key;
                    key_loaded      <= 1'b1;
                    cnt             <= '0;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_data  <= core_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        key_loaded <= 1'b0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (key_flush) begin
                key_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Randomized two-channel bench for aes_req_scheduler with a request-level reference model and response scoreboard.
module tb_aes_req_scheduler;
    import aes_sched_pkg::*;

    localparam int DW = 128;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          r0_valid, r0_ready, r0_encrypt;
    logic [DW-1:0] r0_data, r0_key;
    logic          r1_valid, r1_ready, r1_encrypt;
    logic [DW-1:0] r1_data, r1_key;
    logic          key_flush;
    logic          core_start, core_sel_cypher, core_key_change;
    logic [DW-1:0] core_data_in, core_key;
    logic          core_done;
    logic [DW-1:0] core_data_out;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    aes_req_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_encrypt(r0_encrypt), .r0_data(r0_data), .r0_key(r0_key),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_encrypt(r1_encrypt), .r1_data(r1_data), .r1_key(r1_key),
        .key_flush(key_flush),
        .core_start(core_start), .core_sel_cypher(core_sel_cypher), .core_key_change(core_key_change),
        .core_data_in(core_data_in), .core_key(core_key), .core_done(core_done), .core_data_out(core_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data)
    );

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        logic [DW-1:0] key;
        logic          enc;
        int            cyc;
    } iss_t;

    typedef struct {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    iss_t          iss_q[$];
    rsp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic          busy_m = 1'b0;
    logic          key_loaded_m = 1'b0;
    logic          last_grant_m = 1'b1;
    logic [DW-1:0] loaded_key_m = '0;
    int            done_at = -1;
    logic [DW-1:0] done_val = '0;
    int            force_delay = 0;
    logic          rsp_pend = 1'b0;
    rsp_t          cur_rsp;
    logic          flush_en = 1'b0;
    logic          hold_rsp = 1'b0;
    logic [DW-1:0] key_pool [3];

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in AES core: result on the scheduled cycle, junk on the data bus otherwise.
    always @(posedge clk) begin
        #1;
        core_done     = (done_at >= 0) && (cyc == done_at);
        core_data_out = core_done ? done_val : rand128();
        rsp_ready     = !hold_rsp && ($urandom_range(0, 3) != 0);
        key_flush     = flush_en && ($urandom_range(0, 24) == 0);
    end

    always @(negedge clk) begin
        iss_t          it;
        rsp_t          er;
        int            d;
        logic [1:0]    exp_rdy;
        logic          exp_kc;
        logic [DW-1:0] res;

        if (!reset) begin
            check("rst_ctrl", DW'({r0_ready, r1_ready, core_start, core_sel_cypher, core_key_change,
                                   rsp_valid, rsp_id, rsp_err}), '0);
            check("rst_data", core_data_in | core_key | rsp_data, '0);
            iss_q.delete();
            exp_q.delete();
            busy_m       = 1'b0;
            key_loaded_m = 1'b0;
            last_grant_m = 1'b1;
            done_at      = -1;
            rsp_pend     = 1'b0;
        end else begin
            exp_rdy = 2'b00;
            if (!busy_m && (r0_valid || r1_valid)) begin
                if (r0_valid && r1_valid) exp_rdy = last_grant_m ? 2'b01 : 2'b10;
                else                      exp_rdy = r1_valid ? 2'b10 : 2'b01;
            end
            check("ready_grant", DW'({r1_ready, r0_ready}), DW'(exp_rdy));

            if (r0_valid && r0_ready) begin
                iss_q.push_back('{id: 1'b0, data: r0_data, key: r0_key, enc: r0_encrypt, cyc: cyc});
                busy_m = 1'b1;
            end
            if (r1_valid && r1_ready) begin
                iss_q.push_back('{id: 1'b1, data: r1_data, key: r1_key, enc: r1_encrypt, cyc: cyc});
                busy_m = 1'b1;
            end

            if (core_start) begin
                if (iss_q.size() == 0) begin
                    fail_now("start_unexpected");
                end else begin
                    it = iss_q.pop_front();
                    check("start_latency", DW'(cyc), DW'(it.cyc + 1));
                    check("core_data_in", core_data_in, it.data);
                    check("core_key", core_key, it.key);
                    check("sel_cypher", DW'(core_sel_cypher), DW'(it.enc));
                    exp_kc = !key_loaded_m || (it.key != loaded_key_m);
                    check("key_change", DW'(core_key_change), DW'(exp_kc));
                    loaded_key_m = it.key;
                    key_loaded_m = 1'b1;

                    if (force_delay != 0) d = force_delay;
                    else begin
                        case ($urandom_range(0, 9))
                            0, 1:    d = 1000;
                            2:       d = TO;
                            3:       d = TO - 1;
                            default: d = $urandom_range(1, 12);
                        endcase
                    end
                    res = rand128();
                    if (d < TO) begin
                        done_at  = cyc + d;
                        done_val = res;
                        exp_q.push_back('{id: it.id, err: 1'b0, data: res, cyc: cyc + d + 1});
                    end else begin
                        // a done that lands in RESP must be ignored
                        done_at      = (d == TO) ? cyc + TO : -1;
                        done_val     = res;
                        key_loaded_m = 1'b0;
                        exp_q.push_back('{id: it.id, err: 1'b1, data: '0, cyc: cyc + TO});
                    end
                end
            end

            if (key_flush) key_loaded_m = 1'b0;

            if (rsp_valid) begin
                if (!rsp_pend) begin
                    if (exp_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                        cur_rsp = '{id: rsp_id, err: rsp_err, data: rsp_data, cyc: cyc};
                    end else begin
                        er = exp_q.pop_front();
                        check("rsp_cycle", DW'(cyc), DW'(er.cyc));
                        check("rsp_id", DW'(rsp_id), DW'(er.id));
                        check("rsp_err", DW'(rsp_err), DW'(er.err));
                        check("rsp_data", rsp_data, er.data);
                        cur_rsp = er;
                    end
                    rsp_pend = 1'b1;
                end else begin
                    check("rsp_hold", {rsp_data[DW-1:2], rsp_id, rsp_err} ^ DW'(0),
                          {cur_rsp.data[DW-1:2], cur_rsp.id, cur_rsp.err});
                end
                if (rsp_ready) begin
                    rsp_pend     = 1'b0;
                    busy_m       = 1'b0;
                    last_grant_m = cur_rsp.id;
                end
            end else if (rsp_pend) begin
                fail_now("rsp_dropped");
                rsp_pend = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with valid released.
    task automatic send_req(input logic ch, input logic [DW-1:0] d, input logic [DW-1:0] k, input logic e);
        bit got = 0;
        if (ch) begin r1_valid = 1'b1; r1_data = d; r1_key = k; r1_encrypt = e; end
        else    begin r0_valid = 1'b1; r0_data = d; r0_key = k; r0_encrypt = e; end
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            got = ch ? (r1_valid && r1_ready) : (r0_valid && r0_ready);
        end
        if (!got) fail_now(ch ? "ch1_accept_timeout" : "ch0_accept_timeout");
        @(posedge clk);
        #1;
        if (ch) r1_valid = 1'b0;
        else    r0_valid = 1'b0;
    endtask

    task automatic channel_run(input logic ch, input int n_req);
        for (int i = 0; i < n_req; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send_req(ch, rand128(), key_pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            @(negedge clk);
            idle = !busy_m && (iss_q.size() == 0) && (exp_q.size() == 0);
        end
        if (!idle) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        r0_valid = 0; r0_encrypt = 0; r0_data = '0; r0_key = '0;
        r1_valid = 0; r1_encrypt = 0; r1_data = '0; r1_key = '0;
        key_flush = 0; core_done = 0; core_data_out = '0; rsp_ready = 0;
        for (int i = 0; i < 3; i++) key_pool[i] = rand128();

        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        flush_en = 1'b1;

        fork
            channel_run(1'b0, 25);
            channel_run(1'b1, 25);
        join
        wait_idle();

        // Long response stall with both channels waiting.
        flush_en    = 1'b0;
        hold_rsp    = 1'b1;
        force_delay = 3;
        fork
            send_req(1'b0, rand128(), key_pool[0], 1'b1);
            send_req(1'b1, rand128(), key_pool[1], 1'b0);
            begin
                repeat (20) @(posedge clk);
                #1;
                hold_rsp = 1'b0;
            end
        join
        wait_idle();

        // Reset while the core is busy: no response may follow.
        force_delay = 1000;
        send_req(1'b0, rand128(), key_pool[0], 1'b1);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        force_delay = 5;
        @(posedge clk);
        #1;
        key_flush = 1'b1;
        @(posedge clk);
        #1;
        key_flush = 1'b0;
        send_req(1'b0, rand128(), key_pool[0], 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
